add8_err_monitor: RTL and testbench

- Streaming error-metrics collector that sits directly downstream of an approximate 8-bit adder instance.
- Per sample it takes the operands and the adder's 9-bit output, recomputes the exact sum and accumulates error statistics over a fixed window:
  - sample count
  - erroneous-sample count (EP numerator)
  - sum of absolute error (MAE numerator)
  - worst-case error (WCE)
- Used in hardware characterisation of candidate adders; the testbench or stimulus generator feeds it exhaustive or random operand streams.

---
 rtl/add8_errmon_pkg.sv | 27 ++
 rtl/add8_err_calc.sv | 43 ++++
 rtl/add8_err_monitor.sv | 202 ++++++++++++++++++++
 tb/tb_add8_err_monitor.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add8_errmon_pkg.sv
// -----------------------------------------------------------------------------
// add8_errmon_pkg
// Shared definitions for the approximate-adder error monitor:
//   - default operand width, counter width and window length
//   - monitor FSM state type
//   - width derivation for the absolute-error accumulator
// Optional feature macro used by the monitor: ADD8_ERRMON_MSE_EN
// -----------------------------------------------------------------------------
package add8_errmon_pkg;

  localparam int W_DEF         = 8;
  localparam int CNT_W_DEF     = 17;
  localparam int N_SAMPLES_DEF = 65536;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Each sample adds at most 2^(W+1)-1, so CNT_W+W+1 bits hold a full window.
  function automatic int sum_w_f(input int cnt_w, input int w);
    return cnt_w + w + 1;
  endfunction

endpackage

// File: rtl/add8_err_calc.sv
// -----------------------------------------------------------------------------
// add8_err_calc
// Pure combinational datapath of the error monitor.
//   a_i, b_i    : operands at the monitor input
//   exact_o     : exact zero-extended sum a_i + b_i (captured by S1)
//   exact_i     : exact sum held in S1
//   approx_i    : approximate adder output held in S1
//   abs_err_o   : |exact_i - approx_i|
//   sq_err_o    : abs_err_o squared (only when ADD8_ERRMON_MSE_EN is defined)
// -----------------------------------------------------------------------------
module add8_err_calc
  import add8_errmon_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   exact_o,
  input  logic [W:0]   exact_i,
  input  logic [W:0]   approx_i,
  output logic [W:0]   abs_err_o
`ifdef ADD8_ERRMON_MSE_EN
  ,
  output logic [2*W+1:0] sq_err_o
`endif
);

  logic signed [W+1:0] diff_s;

  assign exact_o = {1'b0, a_i} + {1'b0, b_i};

  // One extra bit of headroom makes the difference of two unsigned W+1 values
  // exactly representable as a signed number.
  assign diff_s = $signed({1'b0, exact_i}) - $signed({1'b0, approx_i});

  // Magnitude never exceeds 2^(W+1)-1, so the low W+1 bits of the negation suffice.
  assign abs_err_o = diff_s[W+1] ? ((~diff_s[W:0]) + {{W{1'b0}}, 1'b1}) : diff_s[W:0];

`ifdef ADD8_ERRMON_MSE_EN
  assign sq_err_o = {{(W+1){1'b0}}, abs_err_o} * {{(W+1){1'b0}}, abs_err_o};
`endif

endmodule

// File: rtl/add8_err_monitor.sv
// -----------------------------------------------------------------------------
// add8_err_monitor
// Streaming error-statistics collector for an approximate W-bit adder.
// Over a window of N_SAMPLES accepted samples it accumulates the sample count,
// erroneous-sample count, sum of absolute error, worst-case error and,
// optionally, the sum of squared error.
// Optional feature macro: ADD8_ERRMON_MSE_EN (squarer + sum_sq_err accumulator;
// when undefined sum_sq_err is tied to zero).
// Ports:
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   start                : one-cycle pulse, clears statistics and opens a window
//   in_valid / in_ready  : sample handshake
//   in_a, in_b, in_o     : operands and approximate adder output
//   busy, done           : window in progress / window complete
//   sample_cnt, err_cnt, sum_abs_err, wce, sum_sq_err : statistics
// -----------------------------------------------------------------------------
module add8_err_monitor
  import add8_errmon_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int SUM_W     = sum_w_f(CNT_W, W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic [W:0]         in_o,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [SUM_W-1:0]   sum_abs_err,
  output logic [W:0]         wce,
  output logic [SUM_W+W:0]   sum_sq_err
);

  if (64'(N_SAMPLES) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_window
    $error("add8_err_monitor: N_SAMPLES does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] sample_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [SUM_W-1:0] sum_abs_err_q;
  logic [W:0]       wce_q;
  logic             s1_vld_q;
  logic             s2_vld_q;
  logic [W:0]       s1_exact_q;
  logic [W:0]       s1_approx_q;
  logic [W:0]       exact_s;
  logic [W:0]       abs_err_s;
  logic             in_ready_s;
  logic             accept_s;
`ifdef ADD8_ERRMON_MSE_EN
  logic [2*W+1:0]   sq_err_s;
  logic [SUM_W+W:0] sum_sq_err_q;
`endif

  add8_err_calc #(.W(W)) u_calc (
    .a_i       (in_a),
    .b_i       (in_b),
    .exact_o   (exact_s),
    .exact_i   (s1_exact_q),
    .approx_i  (s1_approx_q),
    .abs_err_o (abs_err_s)
`ifdef ADD8_ERRMON_MSE_EN
    ,
    .sq_err_o  (sq_err_s)
`endif
  );

  // Next-state and handshake decode; start overrides every state and blocks acceptance.
  always_comb begin
    state_d    = state_q;
    in_ready_s = 1'b0;
    if (start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          in_ready_s = 1'b1;
          if (in_valid && (sample_cnt_q == LAST_CNT)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (!s1_vld_q && !s2_vld_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign accept_s = in_valid && in_ready_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accepted-sample counter, visible the cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= {CNT_W{1'b0}};
    end else if (start) begin
      sample_cnt_q <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      sample_cnt_q <= sample_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // S1: capture exact sum and approximate output of each accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_exact_q  <= {(W+1){1'b0}};
      s1_approx_q <= {(W+1){1'b0}};
    end else begin
      s1_vld_q <= accept_s;
      if (accept_s) begin
        s1_exact_q  <= exact_s;
        s1_approx_q <= in_o;
      end
    end
  end

  // S2 valid: marks that the accumulators absorbed a sample on the last edge,
  // so DRAIN only finishes once the statistics have settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q <= 1'b0;
    end else if (start) begin
      s2_vld_q <= 1'b0;
    end else begin
      s2_vld_q <= s1_vld_q;
    end
  end

  // S2 accumulators; start discards whatever sits in S1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q     <= {CNT_W{1'b0}};
      sum_abs_err_q <= {SUM_W{1'b0}};
      wce_q         <= {(W+1){1'b0}};
    end else if (start) begin
      err_cnt_q     <= {CNT_W{1'b0}};
      sum_abs_err_q <= {SUM_W{1'b0}};
      wce_q         <= {(W+1){1'b0}};
    end else if (s1_vld_q) begin
      err_cnt_q     <= err_cnt_q + {{(CNT_W-1){1'b0}}, (abs_err_s != {(W+1){1'b0}})};
      sum_abs_err_q <= sum_abs_err_q + {{CNT_W{1'b0}}, abs_err_s};
      if (abs_err_s > wce_q) begin
        wce_q <= abs_err_s;
      end
    end
  end

`ifdef ADD8_ERRMON_MSE_EN
  // Squared-error accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_sq_err_q <= {(SUM_W+W+1){1'b0}};
    end else if (start) begin
      sum_sq_err_q <= {(SUM_W+W+1){1'b0}};
    end else if (s1_vld_q) begin
      sum_sq_err_q <= sum_sq_err_q + {{CNT_W{1'b0}}, sq_err_s};
    end
  end

  assign sum_sq_err = sum_sq_err_q;
`else
  assign sum_sq_err = {(SUM_W+W+1){1'b0}};
`endif

  assign in_ready    = in_ready_s;
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign sample_cnt  = sample_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign sum_abs_err = sum_abs_err_q;
  assign wce         = wce_q;

endmodule

// File: tb/tb_add8_err_monitor.sv
// -----------------------------------------------------------------------------
// tb_add8_err_monitor
// Self-checking bench for add8_err_monitor. A main instance (4096-sample
// window) is checked every cycle against a window-level behavioural model;
// a second instance with a one-sample window pins exact literal results.
// -----------------------------------------------------------------------------
module tb_add8_err_monitor;

  localparam int W      = 8;
  localparam int CNT_W  = 13;
  localparam int N      = 4096;
  localparam int SUM_W  = CNT_W + W + 1;
  localparam int CNT1_W = 17;
  localparam int SUM1_W = CNT1_W + W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // main instance
  logic               start = 1'b0;
  logic               in_valid = 1'b0;
  logic [W-1:0]       in_a = '0;
  logic [W-1:0]       in_b = '0;
  logic [W:0]         in_o = '0;
  logic               in_ready, busy, done;
  logic [CNT_W-1:0]   sample_cnt, err_cnt;
  logic [SUM_W-1:0]   sum_abs_err;
  logic [W:0]         wce;
  logic [SUM_W+W:0]   sum_sq_err;

  // one-sample-window instance
  logic               start1 = 1'b0;
  logic               v1 = 1'b0;
  logic [W-1:0]       a1 = '0;
  logic [W-1:0]       b1 = '0;
  logic [W:0]         o1 = '0;
  logic               in_ready1, busy1, done1;
  logic [CNT1_W-1:0]  sample_cnt1, err_cnt1;
  logic [SUM1_W-1:0]  sum_abs_err1;
  logic [W:0]         wce1;
  logic [SUM1_W+W:0]  sum_sq_err1;

  int n_checks = 0;
  int n_fail   = 0;

  add8_err_monitor #(.W(W), .CNT_W(CNT_W), .N_SAMPLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_o(in_o), .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sum_abs_err(sum_abs_err),
    .wce(wce), .sum_sq_err(sum_sq_err)
  );

  add8_err_monitor #(.W(W), .CNT_W(CNT1_W), .N_SAMPLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(v1), .in_ready(in_ready1),
    .in_a(a1), .in_b(b1), .in_o(o1), .busy(busy1), .done(done1),
    .sample_cnt(sample_cnt1), .err_cnt(err_cnt1), .sum_abs_err(sum_abs_err1),
    .wce(wce1), .sum_sq_err(sum_sq_err1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Lower-part-OR approximate adder: low 3 bits OR'ed, carry guessed from bit 2.
  function automatic int loa(input int a, input int b);
    return ((((a >> 3) + (b >> 3) + ((a >> 2) & (b >> 2) & 1)) << 3) | ((a | b) & 7));
  endfunction

  function automatic int abs_i(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // ---------------- window-level reference model (main instance) -------------
  bit     m_active;
  int     m_cnt, m_err, m_wce, m_last, cyc;
  longint m_sum, m_sq;
  bit     pend_v;
  int     pend_e;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0; m_cnt = 0; m_err = 0; m_wce = 0; m_sum = 0; m_sq = 0;
      m_last = -100; pend_v = 1'b0; pend_e = 0; cyc = 0;
    end else begin
      cyc++;
      if (start) begin
        m_active = 1'b1; m_cnt = 0; m_err = 0; m_wce = 0; m_sum = 0; m_sq = 0;
        m_last = -100; pend_v = 1'b0;
      end else begin
        // sample accepted one edge ago lands in the statistics now
        if (pend_v) begin
          if (pend_e != 0) m_err++;
          m_sum += pend_e;
          if (pend_e > m_wce) m_wce = pend_e;
          m_sq += longint'(pend_e) * longint'(pend_e);
          pend_v = 1'b0;
        end
        if (m_active && (m_cnt < N) && in_valid) begin
          m_cnt++;
          pend_v = 1'b1;
          pend_e = abs_i(int'(in_a) + int'(in_b) - int'(in_o));
          m_last = cyc;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------------
  initial forever begin
    bit     d_exp;
    longint sq_exp;
    @(negedge clk);
    d_exp = m_active && (m_cnt == N) && ((cyc - m_last) >= 3);
`ifdef ADD8_ERRMON_MSE_EN
    sq_exp = m_sq;
`else
    sq_exp = 0;
`endif
    check("cyc in_ready", longint'(in_ready), longint'(m_active && (m_cnt < N) && !start));
    check("cyc busy", longint'(busy), longint'(m_active && !d_exp));
    check("cyc done", longint'(done), longint'(d_exp));
    check("cyc sample_cnt", longint'(sample_cnt), longint'(m_cnt));
    check("cyc err_cnt", longint'(err_cnt), longint'(m_err));
    check("cyc sum_abs_err", longint'(sum_abs_err), m_sum);
    check("cyc wce", longint'(wce), longint'(m_wce));
    check("cyc sum_sq_err", longint'(sum_sq_err), sq_exp);
  end

  task automatic drive(input bit s, input bit v, input int a, input int b, input int o);
    @(posedge clk);
    #2;
    start = s; in_valid = v;
    in_a = W'(a); in_b = W'(b); in_o = (W+1)'(o);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((done !== 1'b1) && (k < 64)) begin
      drive(1'b0, 1'b0, 0, 0, 0);
      k++;
    end
    check(name, longint'(done), 1);
  endtask

  task automatic drive1(input bit s, input bit v, input int a, input int b, input int o);
    @(posedge clk);
    #2;
    start1 = s; v1 = v; a1 = W'(a); b1 = W'(b); o1 = (W+1)'(o);
  endtask

  // ---------------- stimulus -------------------------------------------------
  initial begin
    int     acc, tn, te, tw, e, a, b, o, v;
    longint ts, tsq;
    longint sq_lit;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset sample_cnt", longint'(sample_cnt), 0);
    check("reset in_ready", longint'(in_ready), 0);
    check("reset busy", longint'(busy), 0);
    check("reset done", longint'(done), 0);
    check("reset wce", longint'(wce), 0);

    // exact adder, in_valid held high
    drive(1'b1, 1'b0, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      a = i & 255;
      b = ((i * 37) >> 3) & 255;
      drive(1'b0, 1'b1, a, b, a + b);
    end
    wait_done("exact done");
    check("exact sample_cnt", longint'(sample_cnt), N);
    check("exact err_cnt", longint'(err_cnt), 0);
    check("exact sum_abs_err", longint'(sum_abs_err), 0);
    check("exact wce", longint'(wce), 0);
    check("exact sum_sq_err", longint'(sum_sq_err), 0);

    // start coincident with a valid sample
    drive(1'b1, 1'b1, 3, 4, 7);
    drive(1'b0, 1'b0, 0, 0, 0);
    #1 check("start+valid sample_cnt", longint'(sample_cnt), 0);

    // 100 samples with arbitrary outputs, then restart mid-window
    acc = 0;
    for (int k = 0; (k < 1000) && (acc < 100); k++) begin
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      a = $urandom_range(0, 255); b = $urandom_range(0, 255); o = $urandom_range(0, 511);
      drive(1'b0, v[0], a, b, o);
      if (v != 0) acc++;
    end
    drive(1'b1, 1'b1, 255, 255, 0);
    drive(1'b0, 1'b0, 0, 0, 0);
    drive(1'b0, 1'b0, 0, 0, 0);
    #1;
    check("restart sample_cnt", longint'(sample_cnt), 0);
    check("restart err_cnt", longint'(err_cnt), 0);
    check("restart sum_abs_err", longint'(sum_abs_err), 0);
    check("restart wce", longint'(wce), 0);

    // full window of approximate-adder samples with random gaps
    tn = 0; te = 0; tw = 0; ts = 0; tsq = 0;
    for (int k = 0; (k < 20000) && (tn < N); k++) begin
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      o = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 511) : loa(a, b);
      drive(1'b0, v[0], a, b, o);
      if (v != 0) begin
        e = abs_i(a + b - o);
        tn++;
        if (e != 0) te++;
        ts += e;
        if (e > tw) tw = e;
        tsq += longint'(e) * longint'(e);
      end
    end
    wait_done("approx done");
`ifndef ADD8_ERRMON_MSE_EN
    tsq = 0;
`endif
    check("approx sample_cnt", longint'(sample_cnt), tn);
    check("approx err_cnt", longint'(err_cnt), te);
    check("approx sum_abs_err", longint'(sum_abs_err), ts);
    check("approx wce", longint'(wce), tw);
    check("approx sum_sq_err", longint'(sum_sq_err), tsq);

    // asynchronous reset in the middle of a window
    drive(1'b1, 1'b0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 511));
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst sample_cnt", longint'(sample_cnt), 0);
    check("async rst err_cnt", longint'(err_cnt), 0);
    check("async rst sum_abs_err", longint'(sum_abs_err), 0);
    check("async rst wce", longint'(wce), 0);
    check("async rst in_ready", longint'(in_ready), 0);
    check("async rst busy", longint'(busy), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 1, 2, 3);
      #1 check("post-reset in_ready", longint'(in_ready), 0);
    end
    drive(1'b0, 1'b0, 0, 0, 0);

    // one-sample window: worst case 255+255 reported as 0
    drive1(1'b1, 1'b0, 0, 0, 0);
    drive1(1'b0, 1'b1, 255, 255, 0);
    #1 check("n1 in_ready", longint'(in_ready1), 1);
    drive1(1'b0, 1'b0, 0, 0, 0);
    #1 check("n1 sample_cnt", longint'(sample_cnt1), 1);
    @(posedge clk); #3;
    check("n1 done at +1", longint'(done1), 0);
    check("n1 wce", longint'(wce1), 510);
    @(posedge clk); #3;
    check("n1 done at +2", longint'(done1), 0);
    @(posedge clk); #3;
    check("n1 done at +3", longint'(done1), 1);
    check("n1 busy", longint'(busy1), 0);
    check("n1 err_cnt", longint'(err_cnt1), 1);
    check("n1 sum_abs_err", longint'(sum_abs_err1), 510);
`ifdef ADD8_ERRMON_MSE_EN
    sq_lit = 260100;
`else
    sq_lit = 0;
`endif
    check("n1 sum_sq_err", longint'(sum_sq_err1), sq_lit);

    // one-sample window: approximate adder on 7+7 returns 15
    drive1(1'b1, 1'b0, 0, 0, 0);
    drive1(1'b0, 1'b1, 7, 7, loa(7, 7));
    drive1(1'b0, 1'b0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    check("loa pin done", longint'(done1), 1);
    check("loa pin wce", longint'(wce1), 1);
    check("loa pin err_cnt", longint'(err_cnt1), 1);
    check("loa pin sum_abs_err", longint'(sum_abs_err1), 1);
`ifdef ADD8_ERRMON_MSE_EN
    sq_lit = 1;
`else
    sq_lit = 0;
`endif
    check("loa pin sum_sq_err", longint'(sum_sq_err1), sq_lit);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
